cia_pipe_adder: RTL

//  Parametrised, pipelined carry-increment adder/subtractor; next generation of the 32-bit CIA for the ALU32 datapath.

---
 rtl/cia_pkg.sv | 17 +
 rtl/cia_blk.sv | 24 ++
 rtl/cia_pipe_adder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cia_pkg.sv
// Shared helpers for the pipelined carry-increment adder: block-count function and
// the stage-1 control record. Signed-overflow fields exist only with CIA_PIPE_OVF_EN.
package cia_pkg;

  function automatic int nblk(input int w, input int b);
    return w / b;
  endfunction

  typedef struct packed {
    logic valid;
`ifdef CIA_PIPE_OVF_EN
    logic a_msb;
    logic b_msb;
`endif
  } cia_s1_ctl_t;

endpackage

// File: rtl/cia_blk.sv
// BLK-bit ripple-carry block used as the stage-1 building unit of the carry-increment adder.
module cia_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  always_comb begin : ripple
    logic [BLK:0] c;
    c    = '0;
    c[0] = ci;
    s    = '0;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[BLK];
  end

endmodule

// File: rtl/cia_pipe_adder.sv
// Two-stage pipelined carry-increment adder/subtractor with valid/ready on both sides.
// Optional signed-overflow output is enabled by defining CIA_PIPE_OVF_EN.
module cia_pipe_adder
  import cia_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CIA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = nblk(WIDTH, BLK);

  if (WIDTH % BLK != 0) begin : g_width_check
    $error("cia_pipe_adder: WIDTH (%0d) must be a multiple of BLK (%0d)", WIDTH, BLK);
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] blk_s;
  logic [NBLK-1:0]  blk_co;

  logic [WIDTH-1:0] bs_d, bs_q;
  logic [NBLK-1:0]  gc_d, gc_q;
  cia_s1_ctl_t      s1_d, s1_q;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;
`ifdef CIA_PIPE_OVF_EN
  logic             ovf_d, ovf_q;
`endif

  logic st2_adv;
  logic accept;

  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
  end

  // Every block sums with carry-in 0 except block 0, which takes the conditioned carry.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cia_blk #(.BLK(BLK)) u_blk (
      .a  (a[k*BLK +: BLK]),
      .b  (b_eff[k*BLK +: BLK]),
      .ci ((k == 0) ? c0 : 1'b0),
      .s  (blk_s[k*BLK +: BLK]),
      .co (blk_co[k])
    );
  end

  always_comb begin
    st2_adv  = s1_q.valid && (!out_valid_q || out_ready);
    in_ready = !s1_q.valid || st2_adv;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    s1_d = s1_q;
    bs_d = bs_q;
    gc_d = gc_q;
    if (in_ready) s1_d.valid = in_valid;
    if (accept) begin
      bs_d = blk_s;
      gc_d = blk_co;
`ifdef CIA_PIPE_OVF_EN
      s1_d.a_msb = a[WIDTH-1];
      s1_d.b_msb = b_eff[WIDTH-1];
`endif
    end
  end

  // Increment chain: a block can either generate or receive a carry, never both, so OR suffices.
  always_comb begin : resolve
    logic [WIDTH-1:0] res;
    logic             rc;
    res = bs_q;
    rc  = gc_q[0];
    for (int k = 1; k < NBLK; k++) begin
      res[k*BLK +: BLK] = bs_q[k*BLK +: BLK] + BLK'(rc);
      rc = gc_q[k] | (rc & (&bs_q[k*BLK +: BLK]));
    end

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef CIA_PIPE_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (st2_adv) begin
      out_valid_d = 1'b1;
      sum_d       = res;
      cout_d      = rc;
`ifdef CIA_PIPE_OVF_EN
      ovf_d       = (s1_q.a_msb == s1_q.b_msb) && (res[WIDTH-1] != s1_q.a_msb);
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      bs_q        <= '0;
      gc_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef CIA_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_q        <= s1_d;
      bs_q        <= bs_d;
      gc_q        <= gc_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef CIA_PIPE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CIA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
